// File: rtl/decryption_pkg.sv
// Shared constants, FSM state type and width helpers for the decryption dispatch slice.
package decryption_pkg;

  localparam int CH_CAESAR  = 0;
  localparam int CH_SCYTALE = 1;
  localparam int CH_ZIGZAG  = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SPLIT = 1'b1
  } dispatch_state_t;

  function automatic int beats_per_word(input int mst_w, input int sys_w);
    return mst_w / sys_w;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/decryption_dispatch_fifo.sv
// Synchronous FIFO with registered storage; push while full is honoured only alongside a pop.
module decryption_dispatch_fifo
  import decryption_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             din,
  input  logic                         pop,
  output logic [WIDTH-1:0]             dout,
  output logic                         full,
  output logic                         empty,
  output logic [cnt_width(DEPTH):0]    count
);

  localparam int PTR_W = cnt_width(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_count == (PTR_W+1)'(0));
  assign full      = (r_count == (PTR_W+1)'(DEPTH));
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);
  assign count     = r_count;
  assign dout      = empty ? {WIDTH{1'b0}} : r_mem[r_rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {(PTR_W+1){1'b0}};
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= {WIDTH{1'b0}};
    end else if (w_do_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/decryption_dispatch.sv
// Splits a word into beats for the selected decryption engine and merges its results into a FIFO.
// Optional DECRYPTION_DISPATCH_BYPASS_EN: select==NUM_CH routes beats straight into the FIFO.
module decryption_dispatch
  import decryption_pkg::*;
#(
  parameter int MST_DWIDTH = 32,
  parameter int SYS_DWIDTH = 8,
  parameter int NUM_CH     = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [$clog2(NUM_CH+1)-1:0]  select,
  input  logic [MST_DWIDTH-1:0]        data_i,
  input  logic                         valid_i,
  output logic                         busy,
  output logic [NUM_CH*SYS_DWIDTH-1:0] eng_data_o,
  output logic [NUM_CH-1:0]            eng_valid_o,
  input  logic [NUM_CH-1:0]            eng_busy_i,
  input  logic [NUM_CH*SYS_DWIDTH-1:0] eng_data_i,
  input  logic [NUM_CH-1:0]            eng_valid_i,
  output logic [SYS_DWIDTH-1:0]        data_o,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic                         overflow
);

  localparam int SEL_W = $clog2(NUM_CH+1);
  localparam int BEATS = beats_per_word(MST_DWIDTH, SYS_DWIDTH);
  localparam int CNT_W = cnt_width(BEATS);
  localparam int FCW   = cnt_width(FIFO_DEPTH) + 1;

  dispatch_state_t             r_state;
  logic [MST_DWIDTH-1:0]       r_shift;
  logic [SEL_W-1:0]            r_act_sel;
  logic [CNT_W-1:0]            r_beat_cnt;
  logic [NUM_CH*SYS_DWIDTH-1:0] r_eng_data;
  logic [NUM_CH-1:0]           r_eng_valid;
  logic                        r_overflow;

  logic [NUM_CH-1:0]           w_sel_oh;
  logic                        w_sel_busy;
  logic                        w_merge_push;
  logic [SYS_DWIDTH-1:0]       w_merge_data;
  logic [SYS_DWIDTH-1:0]       w_top_beat;
  logic                        w_is_bypass;
  logic                        w_bad_sel;
  logic                        w_accept;
  logic                        w_beat_ok;
  logic                        w_fifo_push;
  logic [SYS_DWIDTH-1:0]       w_fifo_din;
  logic                        w_fifo_full;
  logic                        w_fifo_empty;
  logic [FCW-1:0]              w_fifo_count;
  logic                        w_drop;

`ifdef DECRYPTION_DISPATCH_BYPASS_EN
  assign w_is_bypass = (r_act_sel == SEL_W'(NUM_CH));
  assign w_bad_sel   = (32'(select) > NUM_CH);
`else
  assign w_is_bypass = 1'b0;
  assign w_bad_sel   = (32'(select) >= NUM_CH);
`endif

  // Decode the active channel and gather its busy, strobe and result byte without indexing out of range.
  always_comb begin
    w_sel_busy   = 1'b0;
    w_merge_push = 1'b0;
    w_merge_data = {SYS_DWIDTH{1'b0}};
    for (int k = 0; k < NUM_CH; k++) begin
      w_sel_oh[k]  = (r_act_sel == SEL_W'(k));
      w_sel_busy   = w_sel_busy   | (eng_busy_i[k]  & w_sel_oh[k]);
      w_merge_push = w_merge_push | (eng_valid_i[k] & w_sel_oh[k]);
      w_merge_data = w_merge_data | (eng_data_i[k*SYS_DWIDTH +: SYS_DWIDTH] & {SYS_DWIDTH{w_sel_oh[k]}});
    end
  end

  assign busy        = (r_state != ST_IDLE) | (|eng_busy_i);
  assign w_accept    = valid_i & ~busy;
  assign w_top_beat  = r_shift[MST_DWIDTH-1 -: SYS_DWIDTH];
  assign w_beat_ok   = (r_state == ST_SPLIT) &
                       (w_is_bypass ? (w_fifo_count != FCW'(FIFO_DEPTH)) : ~w_sel_busy);
  assign w_fifo_push = w_merge_push | (w_beat_ok & w_is_bypass);
  assign w_fifo_din  = w_is_bypass ? w_top_beat : w_merge_data;
  assign w_drop      = w_merge_push & w_fifo_full & ~(ready_i & ~w_fifo_empty);

  // Split FSM: latch on accept, then issue one beat per non-stalled cycle, MSB first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_shift     <= {MST_DWIDTH{1'b0}};
      r_act_sel   <= {SEL_W{1'b0}};
      r_beat_cnt  <= {CNT_W{1'b0}};
      r_eng_data  <= {(NUM_CH*SYS_DWIDTH){1'b0}};
      r_eng_valid <= {NUM_CH{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_eng_valid <= {NUM_CH{1'b0}};
          if (w_accept && !w_bad_sel) begin
            r_shift    <= data_i;
            r_act_sel  <= select;
            r_beat_cnt <= {CNT_W{1'b0}};
            r_state    <= ST_SPLIT;
          end
        end
        ST_SPLIT: begin
          if (w_beat_ok) begin
            r_eng_valid <= w_sel_oh;
            for (int k = 0; k < NUM_CH; k++) begin
              if (w_sel_oh[k]) r_eng_data[k*SYS_DWIDTH +: SYS_DWIDTH] <= w_top_beat;
            end
            r_shift    <= r_shift << SYS_DWIDTH;
            r_beat_cnt <= r_beat_cnt + CNT_W'(1);
            if (r_beat_cnt == CNT_W'(BEATS-1)) r_state <= ST_IDLE;
          end else begin
            r_eng_valid <= {NUM_CH{1'b0}};
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_eng_valid <= {NUM_CH{1'b0}};
        end
      endcase
    end
  end

  // Sticky overflow: a result byte lost to a full FIFO, or a word rejected for an invalid select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (w_drop || (w_accept && w_bad_sel)) begin
      r_overflow <= 1'b1;
    end
  end

  decryption_dispatch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (SYS_DWIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_fifo_push),
    .din   (w_fifo_din),
    .pop   (ready_i),
    .dout  (data_o),
    .full  (w_fifo_full),
    .empty (w_fifo_empty),
    .count (w_fifo_count)
  );

  assign valid_o     = ~w_fifo_empty;
  assign eng_data_o  = r_eng_data;
  assign eng_valid_o = r_eng_valid;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_decryption_dispatch.sv
// Directed self-checking bench for decryption_dispatch; inputs driven and outputs sampled on negedge.
module tb_decryption_dispatch;
  import decryption_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [1:0]  select;
  logic [31:0] data_i;
  logic        valid_i;
  logic        busy;
  logic [23:0] eng_data_o;
  logic [2:0]  eng_valid_o;
  logic [2:0]  eng_busy_i;
  logic [23:0] eng_data_i;
  logic [2:0]  eng_valid_i;
  logic [7:0]  data_o;
  logic        valid_o;
  logic        ready_i;
  logic        overflow;

  int n_tests = 0;
  int n_fail  = 0;

  decryption_dispatch #(
    .MST_DWIDTH (32),
    .SYS_DWIDTH (8),
    .NUM_CH     (3),
    .FIFO_DEPTH (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .select      (select),
    .data_i      (data_i),
    .valid_i     (valid_i),
    .busy        (busy),
    .eng_data_o  (eng_data_o),
    .eng_valid_o (eng_valid_o),
    .eng_busy_i  (eng_busy_i),
    .eng_data_i  (eng_data_i),
    .eng_valid_i (eng_valid_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a word for one cycle; returns at the negedge just after the accepting edge.
  task automatic send_word(input logic [1:0] sel, input logic [31:0] word);
    select  = sel;
    data_i  = word;
    valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  logic [7:0] exp_t1 [4];
  logic [7:0] exp_t2 [8];
  logic       vld_t2 [8];

  initial begin
    rst_n = 1'b0; select = 2'd0; data_i = 32'h0; valid_i = 1'b0;
    eng_busy_i = 3'b000; eng_data_i = 24'h0; eng_valid_i = 3'b000; ready_i = 1'b0;
    exp_t1 = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    exp_t2 = '{8'hA1, 8'hB2, 8'h00, 8'h00, 8'h00, 8'hC3, 8'hD4, 8'h00};
    vld_t2 = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    repeat (3) @(negedge clk);
    check_eq("rst_busy", {31'h0, busy}, 32'h0);
    check_eq("rst_eng_valid", {29'h0, eng_valid_o}, 32'h0);
    check_eq("rst_eng_data", {8'h0, eng_data_o}, 32'h0);
    check_eq("rst_valid_o", {31'h0, valid_o}, 32'h0);
    check_eq("rst_data_o", {24'h0, data_o}, 32'h0);
    check_eq("rst_overflow", {31'h0, overflow}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: four beats on channel 1, busy held while splitting
    send_word(2'(CH_SCYTALE), 32'hA1B2C3D4);
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) check_eq($sformatf("t1_busy%0d", i), {31'h0, busy}, 32'h1);
      else       check_eq("t1_busy_end", {31'h0, busy}, 32'h0);
      if (i > 0) begin
        check_eq($sformatf("t1_vld%0d", i), {29'h0, eng_valid_o}, 32'h2);
        check_eq($sformatf("t1_dat%0d", i), {24'h0, eng_data_o[15:8]}, {24'h0, exp_t1[i-1]});
      end
      @(negedge clk);
    end
    check_eq("t1_vld_after", {29'h0, eng_valid_o}, 32'h0);

    // 2: engine 1 busy for 3 cycles after beat B2
    send_word(2'(CH_SCYTALE), 32'hA1B2C3D4);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 1) eng_busy_i = 3'b010;
      if (i == 4) eng_busy_i = 3'b000;
      check_eq($sformatf("t2_vld%0d", i), {31'h0, eng_valid_o[1]}, {31'h0, vld_t2[i]});
      if (vld_t2[i]) check_eq($sformatf("t2_dat%0d", i), {24'h0, eng_data_o[15:8]}, {24'h0, exp_t2[i]});
    end

    // 3: engine 0 streams 6 bytes into a 4-deep FIFO with downstream stalled
    send_word(2'(CH_CAESAR), 32'h0);
    repeat (5) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      eng_valid_i = 3'b001;
      eng_data_i  = {16'h0, 8'h10 + 8'(i)};
      @(negedge clk);
      if (i == 0) begin
        check_eq("t3_valid_first", {31'h0, valid_o}, 32'h1);
        check_eq("t3_head_first", {24'h0, data_o}, 32'h10);
      end
      if (i == 3) check_eq("t3_ovf_at_full", {31'h0, overflow}, 32'h0);
      if (i == 4) check_eq("t3_ovf_drop", {31'h0, overflow}, 32'h1);
    end
    eng_valid_i = 3'b000;
    ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("t3_valid%0d", i), {31'h0, valid_o}, 32'h1);
      check_eq($sformatf("t3_out%0d", i), {24'h0, data_o}, 32'h10 + i);
      @(negedge clk);
    end
    check_eq("t3_empty", {31'h0, valid_o}, 32'h0);
    check_eq("t3_ovf_sticky", {31'h0, overflow}, 32'h1);
    ready_i = 1'b0;

    // 4: strobes from a non-selected engine are ignored
    eng_valid_i = 3'b100;
    eng_data_i  = 24'hEE0000;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_eq($sformatf("t4_valid%0d", i), {31'h0, valid_o}, 32'h0);
    end
    eng_valid_i = 3'b000;
    eng_data_i  = 24'h0;

    // 5: reset after two beats, then a fresh word restarts at its MSB
    send_word(2'(CH_SCYTALE), 32'h55667788);
    repeat (2) @(negedge clk);
    check_eq("t5_pre_beat", {24'h0, eng_data_o[15:8]}, 32'h66);
    rst_n = 1'b0;
    #1;
    check_eq("t5_rst_eng_valid", {29'h0, eng_valid_o}, 32'h0);
    check_eq("t5_rst_eng_data", {8'h0, eng_data_o}, 32'h0);
    check_eq("t5_rst_busy", {31'h0, busy}, 32'h0);
    check_eq("t5_rst_overflow", {31'h0, overflow}, 32'h0);
    check_eq("t5_rst_valid_o", {31'h0, valid_o}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_word(2'(CH_ZIGZAG), 32'h99AABBCC);
    @(negedge clk);
    check_eq("t5_restart_vld", {29'h0, eng_valid_o}, 32'h4);
    check_eq("t5_restart_msb", {24'h0, eng_data_o[23:16]}, 32'h99);
    @(negedge clk);
    check_eq("t5_restart_b1", {24'h0, eng_data_o[23:16]}, 32'hAA);
    repeat (4) @(negedge clk);

    // 6: select == NUM_CH
`ifdef DECRYPTION_DISPATCH_BYPASS_EN
    send_word(2'd3, 32'h01020304);
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("t6_no_eng%0d", i), {29'h0, eng_valid_o}, 32'h0);
      @(negedge clk);
    end
    ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("t6_valid%0d", i), {31'h0, valid_o}, 32'h1);
      check_eq($sformatf("t6_out%0d", i), {24'h0, data_o}, 32'h1 + i);
      @(negedge clk);
    end
    ready_i = 1'b0;
    check_eq("t6_empty", {31'h0, valid_o}, 32'h0);
    check_eq("t6_no_ovf", {31'h0, overflow}, 32'h0);
`else
    send_word(2'd3, 32'h01020304);
    check_eq("t6_ovf", {31'h0, overflow}, 32'h1);
    check_eq("t6_idle", {31'h0, busy}, 32'h0);
    @(negedge clk);
    check_eq("t6_no_eng", {29'h0, eng_valid_o}, 32'h0);
    check_eq("t6_no_out", {31'h0, valid_o}, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
